// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks destination registers of in-flight loads and stalls
// decode on RAW/WAW hazards or when the outstanding-load budget is exhausted.
module load_scoreboard #(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             wb_ld_valid,
    input  logic [4:0]       wb_ld_rd,
    output logic             stall_id,
    output logic [3:0]       outstanding,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             hang_err,
    output logic             proto_err
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);
    localparam logic [3:0]       OUT_MAX  = 4'(MAX_OUT);

    logic [31:1]      pending;
    logic [31:1]      set_vec;
    logic [31:1]      clr_vec;
    logic [31:0]      pend_vec;
    logic [RUN_W-1:0] run_cnt;

    logic raw_hit;
    logic waw_hit;
    logic cap_hit;
    logic issue;
    logic issue_trk;
    logic cmp_ok;
    logic cmp_bad;

    // x0 is never pending, so index 0 reads as a constant zero.
    assign pend_vec = {pending, 1'b0};

    assign raw_hit = (id_use_rs1 & pend_vec[id_rs1]) | (id_use_rs2 & pend_vec[id_rs2]);
    assign waw_hit = id_reg_write & pend_vec[id_rd];
    assign cap_hit = id_is_load & (outstanding == OUT_MAX);

    // Hazards look only at registered state; a same-cycle completion is
    // picked up by the forwarding unit one cycle later.
    assign stall_id = id_valid & (raw_hit | waw_hit | cap_hit);

    assign issue     = id_valid & ~stall_id & id_is_load & id_reg_write;
    assign issue_trk = issue & (id_rd != 5'd0);
    assign cmp_ok    = wb_ld_valid & pend_vec[wb_ld_rd];
    assign cmp_bad   = wb_ld_valid & ~pend_vec[wb_ld_rd];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < 32; i++) begin
            set_vec[i] = issue_trk & (id_rd == 5'(i));
            clr_vec[i] = cmp_ok & (wb_ld_rd == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
        end
    end

    // Issue and completion of different registers in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (issue_trk & ~cmp_ok) begin
            if (outstanding != OUT_MAX) begin
                outstanding <= outstanding + 4'd1;
            end
        end else if (cmp_ok & ~issue_trk) begin
            if (outstanding != 4'd0) begin
                outstanding <= outstanding - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_id && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!stall_id) begin
            run_cnt <= '0;
        end else if (run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // hang_err lands on the same edge that brings the run counter to TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hang_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (stall_id && (run_cnt >= RUN_LAST)) begin
                hang_err <= 1'b1;
            end
            if (cmp_bad) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard: directed scenarios followed by random
// traffic, checked against a set-based reference model of in-flight loads.
module tb_load_scoreboard;

    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit       v, u1, u2, rw, ld, wv;
        bit [4:0] rs1, rs2, rd, wrd;
    } stim_t;

    typedef struct {
        bit stall;
        int outs;
        int scyc;
        bit hang;
        bit proto;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0;
    logic [4:0]       id_rs2 = '0;
    logic             id_use_rs1 = 1'b0;
    logic             id_use_rs2 = 1'b0;
    logic [4:0]       id_rd = '0;
    logic             id_reg_write = 1'b0;
    logic             id_is_load = 1'b0;
    logic             wb_ld_valid = 1'b0;
    logic [4:0]       wb_ld_rd = '0;
    logic             stall_id;
    logic [3:0]       outstanding;
    logic [CNT_W-1:0] stall_cycles;
    logic             hang_err;
    logic             proto_err;

    load_scoreboard #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .wb_ld_valid(wb_ld_valid), .wb_ld_rd(wb_ld_rd),
        .stall_id(stall_id), .outstanding(outstanding), .stall_cycles(stall_cycles),
        .hang_err(hang_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    exp_t exp_q[$];

    // Reference model: the set of registers with a load in flight.
    bit m_pend[32];
    int m_scyc, m_run;
    bit m_hang, m_proto;

    function automatic int pend_count();
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_scyc = 0; m_run = 0; m_hang = 1'b0; m_proto = 1'b0;
    endtask

    function automatic stim_t st(int v = 0, int ld = 0, int rw = 0, int rd = 0,
                                 int u1 = 0, int rs1 = 0, int wv = 0, int wrd = 0);
        stim_t s;
        s.v = (v != 0); s.ld = (ld != 0); s.rw = (rw != 0); s.rd = 5'(rd);
        s.u1 = (u1 != 0); s.rs1 = 5'(rs1); s.u2 = 1'b0; s.rs2 = 5'd0;
        s.wv = (wv != 0); s.wrd = 5'(wrd);
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        int    plist[$];
        s.v   = ($urandom_range(0, 9) != 0);
        s.rs1 = 5'($urandom_range(0, 7));
        s.rs2 = 5'($urandom_range(0, 7));
        s.u1  = ($urandom_range(0, 1) == 1);
        s.u2  = ($urandom_range(0, 2) == 0);
        s.ld  = ($urandom_range(0, 2) == 0);
        s.rw  = s.ld ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
        s.rd  = 5'($urandom_range(0, 10));
        s.wv  = ($urandom_range(0, 3) == 0);
        for (int i = 1; i < 32; i++) if (m_pend[i]) plist.push_back(i);
        if (plist.size() != 0 && $urandom_range(0, 15) != 0)
            s.wrd = 5'(plist[$urandom_range(0, plist.size() - 1)]);
        else
            s.wrd = 5'($urandom_range(0, 10));
        return s;
    endfunction

    // Drive one cycle's inputs, queue the expected outputs, advance the model.
    task automatic eval_push_update(input stim_t s);
        exp_t e;
        bit   stall, iss, ok;
        id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rd = s.rd;
        id_reg_write = s.rw; id_is_load = s.ld;
        wb_ld_valid = s.wv; wb_ld_rd = s.wrd;

        stall = s.v && ((s.u1 && m_pend[s.rs1]) || (s.u2 && m_pend[s.rs2]) ||
                        (s.rw && m_pend[s.rd]) || (s.ld && pend_count() == MAX_OUT));
        e.stall = stall; e.outs = pend_count(); e.scyc = m_scyc;
        e.hang = m_hang; e.proto = m_proto;
        exp_q.push_back(e);

        iss = s.v && !stall && s.ld && s.rw;
        ok  = s.wv && (s.wrd != 0) && m_pend[s.wrd];
        if (s.wv && !ok) m_proto = 1'b1;
        if (ok) m_pend[s.wrd] = 1'b0;
        if (iss && s.rd != 0) m_pend[s.rd] = 1'b1;
        if (stall) begin
            if (m_scyc < CNT_MAX) m_scyc++;
            if (m_run < TIMEOUT) m_run++;
            if (m_run >= TIMEOUT) m_hang = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        eval_push_update(s);
    endtask

    task automatic reset_pulse(input stim_t s);
        @(posedge clk);
        #1;
        eval_push_update(s);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        model_reset();
        eval_push_update(s);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, n_cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        n_cyc++;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_id", int'(stall_id), int'(e.stall));
            chk("outstanding", int'(outstanding), e.outs);
            chk("stall_cycles", int'(stall_cycles), e.scyc);
            chk("hang_err", int'(hang_err), int'(e.hang));
            chk("proto_err", int'(proto_err), int'(e.proto));
        end
    end

    initial begin
        model_reset();
        #2;
        eval_push_update(st());
        #10;
        rst_n = 1'b1;

        // Load-use: load x5, dependent read stalls until one cycle after completion.
        step(st(1, 1, 1, 5));
        repeat (3) step(st(1, 0, 0, 0, 1, 5));
        step(st(1, 0, 0, 0, 1, 5, 1, 5));
        step(st(1, 0, 0, 0, 1, 5));
        step(st());

        // x0 is never tracked; a completion for it is a protocol error.
        step(st(1, 1, 1, 0));
        step(st(1, 0, 0, 0, 1, 0));
        step(st(0, 0, 0, 0, 0, 0, 1, 0));
        step(st());

        // Capacity: four loads fill the budget, a fifth waits for a completion.
        for (int r = 1; r <= 4; r++) step(st(1, 1, 1, r));
        repeat (2) step(st(1, 1, 1, 6));
        step(st(1, 1, 1, 6, 0, 0, 1, 2));
        step(st(1, 1, 1, 6));
        step(st());

        // WAW on x7, then simultaneous completion of x3 and issue of x9.
        step(st(0, 0, 0, 0, 0, 0, 1, 1));
        step(st(1, 1, 1, 7));
        repeat (2) step(st(1, 0, 1, 7));
        step(st(0, 0, 0, 0, 0, 0, 1, 4));
        step(st(1, 1, 1, 9, 0, 0, 1, 3));
        step(st(1, 0, 0, 0, 1, 3));
        step(st(1, 0, 0, 0, 1, 9));

        // Hang: stall on x6 past TIMEOUT, then release; hang_err stays set.
        repeat (TIMEOUT + 2) step(st(1, 0, 0, 0, 1, 6));
        step(st(1, 0, 0, 0, 1, 6, 1, 6));
        step(st(1, 0, 0, 0, 1, 6));
        step(st());

        // Reset mid-flight with three loads pending and a dependent in ID.
        step(st(1, 1, 1, 10));
        reset_pulse(st(1, 0, 0, 0, 1, 7));
        step(st(1, 0, 0, 0, 1, 7));
        step(st());

        repeat (400) step(rnd_stim());
        reset_pulse(rnd_stim());
        repeat (300) step(rnd_stim());
        step(st());

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d queued expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
